// File: rtl/ram_bist.sv
// ram_bist: built-in self-test controller for a single-port 2^AW x DW RAM.
//
// The test makes two passes over the RAM. Each pass writes a pattern to every address,
// reads every address back and compares it, then spends one drain cycle. Pass 0 writes
// P(a) = a ^ SEED and pass 1 writes ~P(a). The block reports pass/fail, a saturating
// error count and the address of the first mismatch.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start_i      level-sampled launch; honoured only in idle or done
//   ram_dout_i   RAM read data, valid the cycle after the read address
//   ram_din_o    RAM write data
//   ram_addr_o   RAM address
//   ram_wr_o     1 = write, 0 = read
//   ram_cs_o     RAM chip select
//   busy_o       test in progress
//   done_o       test complete; held until the next start
//   pass_o       done with zero mismatches
//   err_cnt_o    mismatch count, saturating at 255
//   fail_addr_o  address of the first mismatch, 0 if there was none
//
// Every output is a flop. Next-state output values are decoded from the next FSM state,
// so there is no combinational path from start_i to the RAM ports.

module ram_bist #(
    parameter int unsigned   AW   = 10,
    parameter int unsigned   DW   = 8,
    parameter logic [DW-1:0] SEED = DW'(8'hA5)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [DW-1:0] ram_dout_i,
    output logic [DW-1:0] ram_din_o,
    output logic [AW-1:0] ram_addr_o,
    output logic          ram_wr_o,
    output logic          ram_cs_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          pass_o,
    output logic [7:0]    err_cnt_o,
    output logic [AW-1:0] fail_addr_o
);

    typedef enum logic [2:0] {
        StIdle,
        StWr0,
        StRd0,
        StDrn0,
        StWr1,
        StRd1,
        StDrn1,
        StDone
    } state_e;

    // The low DW bits of the address are XORed with SEED. The address is zero-extended
    // when AW < DW. When inv is set, the result is inverted for the second pass.
    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a, input logic inv);
        logic [AW+DW-1:0] wide;
        wide    = {{DW{1'b0}}, a};
        pattern = (wide[DW-1:0] ^ SEED) ^ {DW{inv}};
    endfunction

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    logic          wr_q, wr_d;
    logic          cs_q, cs_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [7:0]    err_q, err_d;
    logic [AW-1:0] fail_q, fail_d;
    logic          first_q, first_d;

    // The compare stage holds the address and the expected data of the read that was
    // issued in the previous cycle.
    logic          cmp_vld_q, cmp_vld_d;
    logic [AW-1:0] cmp_addr_q, cmp_addr_d;
    logic [DW-1:0] exp_q, exp_d;

    logic          last_addr;
    logic          clear;
    logic          mismatch;
    logic          wr_phase;
    logic          rd_phase;

    assign last_addr = &addr_q;

    // FSM next state and address sequencing. The address wraps to 0 only on a phase change.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        clear   = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d = StWr0;
                    addr_d  = '0;
                    clear   = 1'b1;
                end
            end
            StWr0: begin
                if (last_addr) begin
                    state_d = StRd0;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            StRd0: begin
                if (last_addr) begin
                    state_d = StDrn0;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            StDrn0: begin
                state_d = StWr1;
                addr_d  = '0;
            end
            StWr1: begin
                if (last_addr) begin
                    state_d = StRd1;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            StRd1: begin
                if (last_addr) begin
                    state_d = StDrn1;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            StDrn1: begin
                state_d = StDone;
                addr_d  = '0;
            end
            default: begin
                state_d = StIdle;
                addr_d  = '0;
            end
        endcase
    end

    // Registered bus and status outputs are decoded from the state being entered.
    always_comb begin
        wr_phase = (state_d == StWr0) || (state_d == StWr1);
        rd_phase = (state_d == StRd0) || (state_d == StRd1);
        cs_d     = wr_phase || rd_phase;
        wr_d     = wr_phase;
        din_d    = wr_phase ? pattern(addr_d, state_d == StWr1) : '0;
        busy_d   = (state_d != StIdle) && (state_d != StDone);
        done_d   = (state_d == StDone);
    end

    // Compare pipeline. The RAM returns data one cycle after the address, so the compare
    // for a read issued in cycle n completes on the edge that ends cycle n+1.
    always_comb begin
        cmp_vld_d  = (state_q == StRd0) || (state_q == StRd1);
        cmp_addr_d = addr_q;
        exp_d      = pattern(addr_q, state_q == StRd1);
        mismatch   = cmp_vld_q && (ram_dout_i != exp_q);

        err_d   = err_q;
        fail_d  = fail_q;
        first_d = first_q;
        if (clear) begin
            err_d   = '0;
            fail_d  = '0;
            first_d = 1'b0;
        end else if (mismatch) begin
            if (err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
            end
            if (!first_q) begin
                fail_d  = cmp_addr_q;
                first_d = 1'b1;
            end
        end
        // pass is taken from the next count so that it agrees with err_cnt on the done edge.
        pass_d = done_d && (err_d == 8'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            din_q      <= '0;
            wr_q       <= 1'b0;
            cs_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            fail_q     <= '0;
            first_q    <= 1'b0;
            cmp_vld_q  <= 1'b0;
            cmp_addr_q <= '0;
            exp_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            wr_q       <= wr_d;
            cs_q       <= cs_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            fail_q     <= fail_d;
            first_q    <= first_d;
            cmp_vld_q  <= cmp_vld_d;
            cmp_addr_q <= cmp_addr_d;
            exp_q      <= exp_d;
        end
    end

    assign ram_din_o   = din_q;
    assign ram_addr_o  = addr_q;
    assign ram_wr_o    = wr_q;
    assign ram_cs_o    = cs_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign err_cnt_o   = err_q;
    assign fail_addr_o = fail_q;

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist. A behavioural 1024 x 8 RAM model supports three modes:
// ideal, bit 0 of address 5 stuck at 0, and read data always zero.

module tb_ram_bist;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] ram_dout;
    logic [7:0] ram_din;
    logic [9:0] ram_addr;
    logic       ram_wr;
    logic       ram_cs;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_cnt;
    logic [9:0] fail_addr;

    ram_bist #(
        .AW  (10),
        .DW  (8),
        .SEED(8'hA5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .ram_dout_i (ram_dout),
        .ram_din_o  (ram_din),
        .ram_addr_o (ram_addr),
        .ram_wr_o   (ram_wr),
        .ram_cs_o   (ram_cs),
        .busy_o     (busy),
        .done_o     (done),
        .pass_o     (pass),
        .err_cnt_o  (err_cnt),
        .fail_addr_o(fail_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: mode 0 is ideal, mode 1 has bit 0 of address 5 stuck at 0,
    // and mode 2 always reads 0.
    int         mode;
    logic [7:0] mem [1024];
    logic [7:0] rdata;

    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_wr) begin
                mem[ram_addr] <= (mode == 1 && ram_addr == 10'd5) ? (ram_din & 8'hFE) : ram_din;
            end else begin
                rdata <= mem[ram_addr];
            end
        end
    end
    assign ram_dout = (mode == 2) ? 8'h00 : rdata;

    int total;
    int bad;
    int cur;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to the negedge inside cycle c. Cycle 1 runs from E0 to E0+1.
    task automatic goto(input int c);
        while (cur < c) begin
            @(negedge clk);
            cur++;
            start = 1'b0;
        end
    endtask

    // Raise start for one edge. On return the bench is at the negedge of cycle 1.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cur   = 1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            cur++;
            n++;
        end
        chk("done_within_bound", int'(done), 1);
    endtask

    task automatic chk_results(input string tag, input int e_err, input int e_fail,
                               input int e_pass);
        chk({tag, ".done"}, int'(done), 1);
        chk({tag, ".busy"}, int'(busy), 0);
        chk({tag, ".err_cnt"}, int'(err_cnt), e_err);
        chk({tag, ".fail_addr"}, int'(fail_addr), e_fail);
        chk({tag, ".pass"}, int'(pass), e_pass);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".cs"}, int'(ram_cs), 0);
        chk({tag, ".wr"}, int'(ram_wr), 0);
        chk({tag, ".addr"}, int'(ram_addr), 0);
        chk({tag, ".din"}, int'(ram_din), 0);
        chk({tag, ".busy"}, int'(busy), 0);
        chk({tag, ".done"}, int'(done), 0);
        chk({tag, ".pass"}, int'(pass), 0);
        chk({tag, ".err_cnt"}, int'(err_cnt), 0);
        chk({tag, ".fail_addr"}, int'(fail_addr), 0);
    endtask

    // Each record gives the cycle, the start input driven after sampling, and the
    // expected bus and status values for that cycle.
    typedef struct {
        int cyc;
        bit st;
        bit cs;
        bit wr;
        int addr;
        bit chk_din;
        int din;
        bit busy;
        bit done;
        bit pass;
    } vec_t;

    vec_t tbl[$];

    initial begin
        total = 0;
        bad   = 0;
        cur   = 0;
        mode  = 0;
        start = 1'b0;
        rst_n = 1'b0;

        tbl.push_back('{1,    0, 1, 1, 'h000, 1, 'hA5, 1, 0, 0});
        tbl.push_back('{2,    0, 1, 1, 'h001, 1, 'hA4, 1, 0, 0});
        tbl.push_back('{100,  1, 1, 1, 'h063, 1, 'hC6, 1, 0, 0});
        tbl.push_back('{1024, 0, 1, 1, 'h3FF, 1, 'h5A, 1, 0, 0});
        tbl.push_back('{1025, 0, 1, 0, 'h000, 0, 'h00, 1, 0, 0});
        tbl.push_back('{1026, 0, 1, 0, 'h001, 0, 'h00, 1, 0, 0});
        tbl.push_back('{2048, 0, 1, 0, 'h3FF, 0, 'h00, 1, 0, 0});
        tbl.push_back('{2049, 0, 0, 0, 'h000, 0, 'h00, 1, 0, 0});
        tbl.push_back('{2050, 0, 1, 1, 'h000, 1, 'h5A, 1, 0, 0});
        tbl.push_back('{2051, 0, 1, 1, 'h001, 1, 'h5B, 1, 0, 0});
        tbl.push_back('{3000, 1, 1, 1, 'h3B6, 1, 'hEC, 1, 0, 0});
        tbl.push_back('{3073, 0, 1, 1, 'h3FF, 1, 'hA5, 1, 0, 0});
        tbl.push_back('{3074, 0, 1, 0, 'h000, 0, 'h00, 1, 0, 0});
        tbl.push_back('{4098, 0, 0, 0, 'h000, 0, 'h00, 1, 0, 0});
        tbl.push_back('{4099, 0, 0, 0, 'h000, 0, 'h00, 0, 1, 1});
        tbl.push_back('{4105, 0, 0, 0, 'h000, 0, 'h00, 0, 1, 1});

        // Reset state
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Ideal RAM, with start re-pulsed at cycles 100 and 3000 (both must be ignored)
        pulse_start();
        for (int i = 0; i < tbl.size(); i++) begin
            string tag;
            goto(tbl[i].cyc);
            tag = $sformatf("ideal@%0d", tbl[i].cyc);
            chk({tag, ".cs"}, int'(ram_cs), int'(tbl[i].cs));
            chk({tag, ".wr"}, int'(ram_wr), int'(tbl[i].wr));
            chk({tag, ".addr"}, int'(ram_addr), tbl[i].addr);
            if (tbl[i].chk_din) chk({tag, ".din"}, int'(ram_din), tbl[i].din);
            chk({tag, ".busy"}, int'(busy), int'(tbl[i].busy));
            chk({tag, ".done"}, int'(done), int'(tbl[i].done));
            chk({tag, ".pass"}, int'(pass), int'(tbl[i].pass));
            chk({tag, ".err_cnt"}, int'(err_cnt), 0);
            chk({tag, ".fail_addr"}, int'(fail_addr), 0);
            start = tbl[i].st;
        end

        // Bit 0 of address 5 stuck at 0: pass 0 is clean and pass 1 fails once
        mode = 1;
        pulse_start();
        goto(2050);
        chk("stuck.err_after_pass0", int'(err_cnt), 0);
        goto(3080);
        chk("stuck.err_before_cmp5", int'(err_cnt), 0);
        goto(3081);
        chk("stuck.err_after_cmp5", int'(err_cnt), 1);
        chk("stuck.fail_after_cmp5", int'(fail_addr), 5);
        wait_done();
        chk_results("stuck", 1, 5, 0);

        // Restart with an ideal RAM: results clear at the start edge
        mode = 0;
        pulse_start();
        chk("rerun.err_cleared", int'(err_cnt), 0);
        chk("rerun.fail_cleared", int'(fail_addr), 0);
        chk("rerun.done_cleared", int'(done), 0);
        chk("rerun.busy", int'(busy), 1);
        wait_done();
        chk_results("rerun", 0, 0, 1);

        // Read data always zero: the count saturates and the first failure is at address 0
        mode = 2;
        pulse_start();
        wait_done();
        chk_results("zero", 255, 0, 0);

        // Asynchronous reset in the middle of WR1
        mode = 0;
        pulse_start();
        goto(2500);
        chk("midrst.busy_before", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        wait_done();
        chk_results("after_rst", 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
